// File: rtl/mmcm_drp_responder_pkg.sv
// Shared widths, MMCM DRP register map and PROTO_ERR bit positions for the
// DRP responder and the controller benches built around it.
package mmcm_drp_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT5_1  = 7'h06;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT5_2  = 7'h07;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT0_1  = 7'h08;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT0_2  = 7'h09;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT1_1  = 7'h0A;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT1_2  = 7'h0B;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT2_1  = 7'h0C;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT2_2  = 7'h0D;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT3_1  = 7'h0E;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT3_2  = 7'h0F;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT4_1  = 7'h10;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT4_2  = 7'h11;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT6_1  = 7'h12;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKOUT6_2  = 7'h13;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKFBOUT_1 = 7'h14;
  localparam logic [DRP_ADDR_W-1:0] REG_CLKFBOUT_2 = 7'h15;
  localparam logic [DRP_ADDR_W-1:0] REG_DIVCLK     = 7'h16;
  localparam logic [DRP_ADDR_W-1:0] REG_LOCK1      = 7'h18;
  localparam logic [DRP_ADDR_W-1:0] REG_LOCK2      = 7'h19;
  localparam logic [DRP_ADDR_W-1:0] REG_LOCK3      = 7'h1A;
  localparam logic [DRP_ADDR_W-1:0] REG_POWER      = 7'h28;
  localparam logic [DRP_ADDR_W-1:0] REG_FILT1      = 7'h4E;
  localparam logic [DRP_ADDR_W-1:0] REG_FILT2      = 7'h4F;

  // Order a full reconfiguration walks the map; POWER goes last.
  localparam int MMCM_REG_CNT = 23;
  localparam logic [DRP_ADDR_W-1:0] MMCM_REG_SEQ [MMCM_REG_CNT] = '{
    REG_CLKOUT0_1, REG_CLKOUT0_2, REG_CLKOUT1_1, REG_CLKOUT1_2,
    REG_CLKOUT2_1, REG_CLKOUT2_2, REG_CLKOUT3_1, REG_CLKOUT3_2,
    REG_CLKOUT4_1, REG_CLKOUT4_2, REG_CLKOUT5_1, REG_CLKOUT5_2,
    REG_CLKOUT6_1, REG_CLKOUT6_2, REG_CLKFBOUT_1, REG_CLKFBOUT_2,
    REG_DIVCLK, REG_LOCK1, REG_LOCK2, REG_LOCK3,
    REG_FILT1, REG_FILT2, REG_POWER
  };

  localparam int ERR_DEN_BUSY   = 0;
  localparam int ERR_DWE_NO_DEN = 1;
  localparam int ERR_WR_RUNNING = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } drp_state_e;

endpackage

// File: rtl/mmcm_drp_responder_if.sv
// DRP bus between an MMCM reconfiguration controller (master) and the
// MMCM primitive or its stand-in (slave).
interface mmcm_drp_responder_if
  import mmcm_drp_pkg::*;
#(
  parameter int ADDR_W = DRP_ADDR_W,
  parameter int DATA_W = DRP_DATA_W
) ();

  logic              DEN;
  logic              DWE;
  logic [ADDR_W-1:0] DADDR;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic              DRDY;

  modport master (output DEN, DWE, DADDR, DI, input DO, DRDY);
  modport slave  (input DEN, DWE, DADDR, DI, output DO, DRDY);

endinterface

// File: rtl/mmcm_drp_responder_lock_model.sv
// Emulated MMCM lock: LOCKED rises LOCK_CYCLES cycles after the MMCM RST pin
// falls; any reassertion of the pin restarts the count.
module mmcm_lock_model #(
  parameter int LOCK_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic MMCM_RST,
  output logic LOCKED
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;

  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (MMCM_RST) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (!locked_q) begin
      cnt_d    = cnt_q + CNT_W'(1);
      locked_d = (cnt_q == CNT_W'(LOCK_CYCLES - 1));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign LOCKED = locked_q;

endmodule

// File: rtl/mmcm_drp_responder.sv
// DRP target standing in for the MMCM primitive: register image, fixed DRDY
// latency, lock emulation, sticky protocol checks. Optional write log: DRP_RESP_WRLOG_EN.
//
// state   | meaning
// ST_IDLE | no transaction pending, next DEN is accepted
// ST_BUSY | transaction captured, latency counting down; DRDY in the cnt==0 cycle
module mmcm_drp_responder
  import mmcm_drp_pkg::*;
#(
  parameter int ADDR_W      = DRP_ADDR_W,
  parameter int DATA_W      = DRP_DATA_W,
  parameter int DRDY_LAT    = 4,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  mmcm_drp_responder_if.slave drp,
  input  logic              MMCM_RST,
  output logic              LOCKED,
  output logic [2:0]        PROTO_ERR
`ifdef DRP_RESP_WRLOG_EN
  ,
  output logic [15:0]       WR_CNT,
  output logic [ADDR_W-1:0] LAST_WADDR
`endif
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] LAT_LOAD = 4'(DRDY_LAT - 1);

  drp_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic [DATA_W-1:0] do_q, do_d;
  logic [2:0]        err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              drdy;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    di_d    = di_q;
    do_d    = do_q;
    err_d   = err_q;
    drdy    = 1'b0;
    mem_we  = 1'b0;
    // A write reflects its own data on DO, so the image is not read for it.
    rd_data = we_q ? di_q : mem_q[addr_q];

    if (drp.DWE && !drp.DEN) err_d[ERR_DWE_NO_DEN] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (drp.DEN) begin
          state_d = ST_BUSY;
          cnt_d   = LAT_LOAD;
          addr_d  = drp.DADDR;
          we_d    = drp.DWE;
          di_d    = drp.DI;
          if (drp.DWE && !MMCM_RST) err_d[ERR_WR_RUNNING] = 1'b1;
        end
      end
      ST_BUSY: begin
        if (drp.DEN) err_d[ERR_DEN_BUSY] = 1'b1;
        if (cnt_q == 4'd0) begin
          drdy    = 1'b1;
          mem_we  = we_q;
          do_d    = rd_data;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      di_q    <= '0;
      do_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      di_q    <= di_d;
      do_q    <= do_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= di_q;
    end
  end

  assign drp.DRDY  = drdy;
  assign drp.DO    = drdy ? rd_data : do_q;
  assign PROTO_ERR = err_q;

`ifdef DRP_RESP_WRLOG_EN
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] last_waddr_q, last_waddr_d;

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    last_waddr_d = last_waddr_q;
    if (mem_we) begin
      if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      last_waddr_d = addr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_cnt_q     <= '0;
      last_waddr_q <= '0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      last_waddr_q <= last_waddr_d;
    end
  end

  // Presented from the next-state values so the log moves with DRDY, like DO.
  assign WR_CNT     = wr_cnt_d;
  assign LAST_WADDR = last_waddr_d;
`endif

  mmcm_lock_model #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock (
    .CLK     (CLK),
    .RST     (RST),
    .MMCM_RST(MMCM_RST),
    .LOCKED  (LOCKED)
  );

endmodule

// File: tb/tb_mmcm_drp_responder.sv
// Bench for mmcm_drp_responder: edge-time reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmcm_drp_responder;
  import mmcm_drp_pkg::*;

  localparam int DRDY_LAT    = 4;
  localparam int LOCK_CYCLES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        mrst;
  logic        locked;
  logic [2:0]  proto_err;
`ifdef DRP_RESP_WRLOG_EN
  logic [15:0] wr_cnt;
  logic [6:0]  last_waddr;
`endif

  mmcm_drp_responder_if #(.ADDR_W(7), .DATA_W(16)) drp_if ();

  mmcm_drp_responder #(
    .ADDR_W(7), .DATA_W(16), .DRDY_LAT(DRDY_LAT), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .CLK(clk), .RST(rst), .drp(drp_if), .MMCM_RST(mrst),
    .LOCKED(locked), .PROTO_ERR(proto_err)
`ifdef DRP_RESP_WRLOG_EN
    , .WR_CNT(wr_cnt), .LAST_WADDR(last_waddr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: transactions as (accept edge, completion edge) pairs.
  int          t = 0;
  bit          m_valid = 0;
  bit          m_busy;
  int          m_done;
  logic [6:0]  m_a;
  bit          m_we;
  logic [15:0] m_d;
  logic [15:0] img [128];
  logic [15:0] m_hold;
  logic [2:0]  m_err;
  int          m_low;
  int          m_wrcnt;
  logic [6:0]  m_lastw;
  logic        exp_drdy;
  logic [15:0] exp_do;
  logic        exp_locked;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_step();
    t++;
    if (rst) begin
      m_busy = 0; m_hold = '0; m_err = '0; m_low = 0;
      m_wrcnt = 0; m_lastw = '0; m_valid = 1;
      for (int i = 0; i < 128; i++) img[i] = '0;
    end else begin
      if (drp_if.DWE && !drp_if.DEN) m_err[1] = 1'b1;
      if (m_busy) begin
        if (drp_if.DEN) m_err[0] = 1'b1;
        if (t == m_done) begin
          m_hold = m_we ? m_d : img[m_a];
          if (m_we) begin
            img[m_a] = m_d;
            if (m_wrcnt < 65535) m_wrcnt++;
            m_lastw = m_a;
          end
          m_busy = 0;
        end
      end else if (drp_if.DEN) begin
        m_busy = 1;
        m_done = t + DRDY_LAT;
        m_a    = drp_if.DADDR;
        m_we   = drp_if.DWE;
        m_d    = drp_if.DI;
        if (drp_if.DWE && !mrst) m_err[2] = 1'b1;
      end
      if (mrst) m_low = 0;
      else      m_low++;
    end
    exp_drdy   = m_busy && (t == m_done - 1);
    exp_do     = exp_drdy ? (m_we ? m_d : img[m_a]) : m_hold;
    exp_locked = (m_low >= LOCK_CYCLES);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("drdy", drp_if.DRDY, exp_drdy);
      chk("do", drp_if.DO, exp_do);
      chk("locked", locked, exp_locked);
      chk("proto_err", proto_err, m_err);
`ifdef DRP_RESP_WRLOG_EN
      chk("wr_cnt", wr_cnt, (exp_drdy && m_we && m_wrcnt < 65535) ? m_wrcnt + 1 : m_wrcnt);
      chk("last_waddr", last_waddr, (exp_drdy && m_we) ? m_a : m_lastw);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drp_if.DEN = 0; drp_if.DWE = 0;
    rst = 1; tick(); rst = 0;
  endtask

  task automatic drp_start(input logic we, input logic [6:0] a, input logic [15:0] d);
    drp_if.DEN = 1; drp_if.DWE = we; drp_if.DADDR = a; drp_if.DI = d;
    tick();
    drp_if.DEN = 0; drp_if.DWE = 0;
  endtask

  // Read and pin DRDY timing plus DO at the completion cycle.
  task automatic read_expect(input string name, input logic [6:0] a, input logic [15:0] v);
    drp_start(1'b0, a, 16'h0);
    for (int k = 0; k < DRDY_LAT; k++) begin
      @(negedge clk);
      chk({name, "_drdy"}, drp_if.DRDY, k == DRDY_LAT - 1);
      if (k == DRDY_LAT - 1) chk({name, "_do"}, drp_if.DO, v);
    end
    tick();
  endtask

  int mrst_hold;

  initial begin
    rst = 1; mrst = 1;
    drp_if.DEN = 0; drp_if.DWE = 0; drp_if.DADDR = '0; drp_if.DI = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_drdy", drp_if.DRDY, 1'b0);
    chk("rst_do", drp_if.DO, 16'h0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_err", proto_err, 3'b000);
    rst = 0;

    // Write then read back with MMCM held in reset.
    do_reset();
    drp_start(1'b1, 7'h08, 16'h1041);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_wr_drdy", drp_if.DRDY, k == 3);
    end
    chk("t1_err", proto_err, 3'b000);
    tick();
    read_expect("t1_rd", 7'h08, 16'h1041);

    // DEN while busy: one DRDY only, second target untouched.
    do_reset();
    drp_start(1'b0, 7'h10, 16'h0);
    tick();
    drp_start(1'b1, 7'h30, 16'hFFFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_drdy", drp_if.DRDY, k == 1);
    end
    chk("t2_err", proto_err, 3'b001);
    tick();
    read_expect("t2_rd", 7'h30, 16'h0000);

    // Lock timing after a fall, then restart on a mid-count pulse.
    mrst = 1;
    repeat (5) tick();
    mrst = 0;
    tick();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("t3_lock", locked, k >= 63);
    end
    tick();
    mrst = 1; repeat (5) tick();
    mrst = 0; repeat (30) tick();
    mrst = 1; tick();
    mrst = 0; tick();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("t3_relock", locked, k >= 63);
    end
    tick();

    // Write while the MMCM runs, then DWE without DEN.
    do_reset();
    drp_start(1'b1, 7'h14, 16'hBEEF);
    repeat (4) tick();
    @(negedge clk);
    chk("t4_err_wr", proto_err, 3'b100);
    tick();
    read_expect("t4_rd", 7'h14, 16'hBEEF);
    drp_if.DWE = 1; tick(); drp_if.DWE = 0;
    @(negedge clk);
    chk("t4_err_dwe", proto_err, 3'b110);
    tick();

    // Block reset mid-write drops the transaction.
    do_reset();
    drp_start(1'b1, 7'h22, 16'h5555);
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_nodrdy", drp_if.DRDY, 1'b0);
    end
    tick();
    read_expect("t5_rd", 7'h22, 16'h0000);

`ifdef DRP_RESP_WRLOG_EN
    do_reset();
    mrst = 1;
    for (int i = 0; i < MMCM_REG_CNT; i++) begin
      drp_start(1'b1, MMCM_REG_SEQ[i], 16'($urandom));
      repeat (DRDY_LAT) tick();
    end
    @(negedge clk);
    chk("t6_wr_cnt", wr_cnt, 16'd23);
    chk("t6_last_waddr", last_waddr, 7'h28);
    tick();
`endif

    // Randomized traffic, clustered addresses so reads hit earlier writes.
    do_reset();
    mrst_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      drp_if.DEN   = ($urandom_range(0, 3) == 0);
      drp_if.DWE   = drp_if.DEN ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 59) == 0);
      drp_if.DADDR = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      drp_if.DI    = 16'($urandom);
      if (mrst_hold > 0) mrst_hold--;
      if ($urandom_range(0, 149) == 0) mrst_hold = $urandom_range(1, 6);
      mrst = (mrst_hold > 0);
      rst  = ($urandom_range(0, 399) == 0);
      tick();
    end
    drp_if.DEN = 0; drp_if.DWE = 0; rst = 0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
